// File: rtl/shiftr_deser.sv
// shiftr_deser: LSB-first serial-to-parallel receiver with valid/ready output and sticky overrun.
// Define SHIFTR_DESER_PARITY_EN to add an even-parity bit after each word (reported on perr).
module shiftr_deser #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             si,
    input  logic             ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             perr
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SHIFTR_DESER_PARITY_EN
    localparam int SW = WIDTH;
`else
    // The final data bit goes straight from si into dout, so one stage less is kept.
    localparam int SW = WIDTH - 1;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shin, word, dout_q;
    logic             cmp, load, drop, valid_q, ovr_q;
`ifdef SHIFTR_DESER_PARITY_EN
    logic             perr_c, perr_q;
`endif

    assign shin = {si, sreg_q[SW-1:SW-WIDTH+1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        word    = shin;
        cmp     = 1'b0;
`ifdef SHIFTR_DESER_PARITY_EN
        perr_c  = 1'b0;
`endif
        if (en) begin
            if (start) begin
                state_d = SHIFT;
                sreg_d  = shin[WIDTH-1:WIDTH-SW];
                cnt_d   = CW'(1);
            end else if (state_q == SHIFT) begin
                sreg_d = shin[WIDTH-1:WIDTH-SW];
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFTR_DESER_PARITY_EN
                    state_d = PAR;
                    cnt_d   = CW'(WIDTH);
`else
                    state_d = IDLE;
                    cnt_d   = '0;
                    cmp     = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SHIFTR_DESER_PARITY_EN
            else if (state_q == PAR) begin
                state_d = IDLE;
                cnt_d   = '0;
                cmp     = 1'b1;
                word    = sreg_q;
                perr_c  = ^{si, sreg_q};
            end
`endif
        end
    end

    // A completed word is only dropped when the previous one is still waiting.
    assign load = cmp & (~valid_q | ready);
    assign drop = cmp & valid_q & ~ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            if (load) begin
                dout_q  <= word;
                valid_q <= 1'b1;
            end else if (valid_q & ready) begin
                valid_q <= 1'b0;
            end
            ovr_q <= (ovr_q & ~ovr_clr) | drop;
        end
    end

`ifdef SHIFTR_DESER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else if (load) perr_q <= perr_c;
    end
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign overrun = ovr_q;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_shiftr_deser.sv
// tb_shiftr_deser: scoreboard bench for shiftr_deser; frame model assembles bits into words arithmetically.
module tb_shiftr_deser;
    localparam int WIDTH = 8;
`ifdef SHIFTR_DESER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk = 0, rst = 1, en = 0, start = 0, si = 0, ready = 0, ovr_clr = 0;
    logic [WIDTH-1:0] dout;
    logic valid, busy, overrun, perr;

    shiftr_deser #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .si(si), .ready(ready),
        .ovr_clr(ovr_clr), .dout(dout), .valid(valid), .busy(busy),
        .overrun(overrun), .perr(perr)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] m_dout = '0;
    bit m_valid = 0, m_ovr = 0, in_frame = 0, done = 0;
    bit bits[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect accepted bits of the current frame; a frame is complete after NB bits.
    task automatic model_step();
        bit cmpl = 0, drop, p = 0;
        logic [WIDTH-1:0] w = '0;
        if (en) begin
            if (start) begin
                in_frame = 1;
                bits.delete();
                bits.push_back(si);
            end else if (in_frame) begin
                bits.push_back(si);
                if (bits.size() == NB) begin
                    cmpl = 1;
                    in_frame = 0;
                end
            end
        end
        if (cmpl) begin
            for (int i = 0; i < WIDTH; i++) w = w + (WIDTH'(bits[i]) << i);
            for (int i = 0; i < NB; i++) p = p ^ bits[i];
        end
        drop = cmpl && m_valid && !ready;
        if (cmpl && !drop) begin
            exp_q.push_back({(NB > WIDTH) ? p : 1'b0, w});
            m_valid = 1;
        end else if (!cmpl && m_valid && ready) begin
            m_valid = 0;
        end
        m_ovr = (m_ovr && !ovr_clr) || drop;
    endtask

    task automatic cyc(input logic e, input logic s, input logic d, input logic r, input logic c);
        @(posedge clk);
        #1;
        model_step();
        en = e; start = s; si = d; ready = r; ovr_clr = c;
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, r, 0);
    endtask

    // enm: 0 en always on, 1 en toggles, 2 random. rm: 0 ready low, 1 ready high, 2 random (+resync/ovr_clr noise).
    task automatic send_frame(input logic [WIDTH-1:0] w, input int enm, input int rm, input logic pbad);
        int i = 0;
        bit ph = 1;
        logic e, r, c, b;
        while (i < NB) begin
            e = (enm == 0) ? 1'b1 : (enm == 1) ? logic'(ph) : logic'($urandom_range(0, 4) != 0);
            ph = !ph;
            r = (rm == 2) ? logic'($urandom_range(0, 3) != 0) : logic'(rm == 1);
            c = (rm == 2) ? logic'($urandom_range(0, 19) == 0) : 1'b0;
            b = (i < WIDTH) ? w[i] : (^w ^ pbad);
            if (!e) begin
                cyc(0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), r, c);
            end else if (rm == 2 && i > 0 && $urandom_range(0, 40) == 0) begin
                cyc(1, 1, logic'($urandom_range(0, 1)), r, c);
            end else begin
                cyc(1, logic'(i == 0), b, r, c);
                i++;
            end
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        model_step();
        rst = 1; en = 0; start = 0; si = 0; ready = 0; ovr_clr = 0;
        #1;
        chk("rst dout", dout, 0);
        chk("rst valid", valid, 0);
        chk("rst busy", busy, 0);
        chk("rst overrun", overrun, 0);
        chk("rst perr", perr, 0);
        m_valid = 0; m_ovr = 0; in_frame = 0; m_dout = '0;
        bits.delete();
        exp_q.delete();
        #1 rst = 0;
    endtask

    initial begin
        @(negedge clk);
        while (!done) begin
            chk("valid", valid, m_valid);
            chk("overrun", overrun, m_ovr);
            chk("busy", busy, in_frame);
            if (m_valid && exp_q.size() != 0) begin
                chk("dout", dout, exp_q[0][WIDTH-1:0]);
                chk("perr", perr, exp_q[0][WIDTH]);
                if (ready) m_dout = exp_q.pop_front();
            end else begin
                chk("dout held", dout, m_dout[WIDTH-1:0]);
                chk("perr held", perr, m_dout[WIDTH]);
            end
            @(negedge clk);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset valid", valid, 0);
        send_frame(8'hA5, 0, 1, 0);
        idle(3, 1);
        send_frame(8'hA5, 1, 1, 0);
        idle(3, 1);
        send_frame(8'h3C, 0, 0, 0);
        send_frame(8'h81, 0, 0, 0);
        idle(2, 0);
        idle(1, 1);
        idle(2, 0);
        cyc(0, 0, 0, 0, 1);
        idle(2, 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        send_frame(8'h5A, 0, 1, 0);
        idle(3, 1);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 1, 1, 0);
        cyc(1, 0, 1, 1, 0);
        reset_pulse();
        send_frame(8'hFF, 0, 1, 0);
        idle(3, 1);
        send_frame(8'hA5, 0, 1, 0);
        idle(2, 1);
        send_frame(8'hA5, 0, 1, 1);
        idle(2, 1);
        send_frame(8'h00, 0, 1, 0);
        send_frame(8'hFF, 0, 1, 0);
        idle(2, 1);
        for (int f = 0; f < 250; f++) begin
            send_frame(WIDTH'($urandom), 2, 2, logic'($urandom_range(0, 1)));
            idle($urandom_range(0, 2), logic'($urandom_range(0, 1)));
        end
        idle(NB + 4, 1);
        done = 1;
        @(negedge clk);
        #1;
        chk("queue drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/shiftr_deser.md
Name: shiftr_deser

Overview:
- Serial-to-parallel receiver: the far end of a right-shifting, LSB-first serial link driven by a load/shift transmitter register.
- Collects WIDTH bits framed by a start strobe, qualified by a global enable.
- Presents each completed word on a parallel output with a valid/ready handshake, plus overrun detection.
- Sits between the serial line and any word-oriented consumer.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  global enable; qualifies si and start (one bit per enabled cycle).
- start  input  1  frame start; marks the current si as data bit 0.
- si  input  1  serial data, LSB first.
- ready  input  1  consumer accepts dout when high together with valid.
- ovr_clr  input  1  synchronous clear of the sticky overrun flag.
- dout  output  WIDTH  received word.
- valid  output  1  dout holds an unconsumed word.
- busy  output  1  frame in progress (state != IDLE).
- overrun  output  1  sticky: a completed word was lost.
- perr  output  1  parity error for the word on dout (see Optional Feature).

Behaviour:
- Reset (async, any state, including mid-frame):
  - state=IDLE, shift reg=0, bit count=0.
  - dout=0, valid=0, busy=0, overrun=0, perr=0.
- Shift rule on each accepted bit: sreg <= {si, sreg[WIDTH-1:1]}. The first bit ends in dout[0].
- Bit counter width is $clog2(WIDTH+1) and counts accepted bits.
- Nothing in the receive path advances when en=0. The handshake and ovr_clr are not gated by en.
- States:
  - IDLE:
    - en&start: capture si, cnt=1, go to SHIFT.
    - Otherwise: hold; si is ignored.
  - SHIFT:
    - en&start: resync. Discard the partial word, capture si as the new bit 0, cnt=1, stay in SHIFT.
    - en&!start and cnt<WIDTH-1: capture si, cnt++.
    - en&!start and cnt==WIDTH-1: capture the final bit and complete the word, then go to IDLE (or PAR when the feature is enabled).
- Completion, at the same clock edge as the final bit capture:
  - Latency: valid rises in the cycle after the edge that samples the last bit.
  - If valid=0, or valid&ready at that edge: dout <= completed word, valid=1.
  - If valid&!ready at that edge: dout keeps the old word, the new word is dropped, overrun <= 1.
- Handshake:
  - valid&ready at an edge with no completion: valid <= 0.
  - dout holds its value after consumption.
  - Back-to-back words need no idle cycle. A new start may coincide with completion only in IDLE. A start in SHIFT always resyncs, even on the cycle that would have been the last bit.
- overrun:
  - Sticky; cleared only by rst or ovr_clr.
  - ovr_clr and a new overrun at the same edge: set wins.
- busy = (state != IDLE). It is combinational from state.

Optional Feature:
- Macro: SHIFTR_DESER_PARITY_EN
- Defined:
  - After WIDTH data bits the FSM enters PAR. The next en cycle samples si as an even-parity bit (XOR of data and parity bits must be 0).
  - Completion, with the handshake and overrun rules above, happens on the parity capture edge. Latency is one more bit than without the feature.
  - perr is loaded with dout: 1 when parity fails. It follows the same drop rule on overrun.
  - start in PAR resyncs exactly as in SHIFT.
- Undefined: no PAR state, perr tied to 0.

Test Plan:
- WIDTH=8, ready=1, en=1: start with bit 0, then send 0xA5 LSB first over 8 cycles -> valid=1 for 1 cycle after the 8th edge, dout=0xA5, busy high for 7 cycles after the first bit.
- Same frame with en toggling every cycle, si changing only on en cycles -> dout=0xA5; no capture on en=0 cycles.
- ready=0: frame 0x3C then frame 0x81 -> dout=0x3C, valid=1, overrun=1. Then ready=1 for 1 cycle -> valid=0, overrun still 1. Then ovr_clr -> overrun=0.
- start, 3 bits, start again, then frame 0x5A -> single word 0x5A, no overrun.
- rst pulsed after 4 bits of a frame -> all outputs 0 immediately. A following full frame 0xFF -> dout=0xFF.
- With SHIFTR_DESER_PARITY_EN: 0xA5 + parity 0 -> perr=0; 0xA5 + parity 1 -> perr=1. In both cases valid rises one bit later than without the macro.
